// File: rtl/adder_tree_arbiter.sv
// Round-robin front end sharing one pipelined adder tree between REQ_NUM requesters.
// Optional issue counter output enabled by defining ADDER_TREE_ARB_ISSUE_CNT_EN.
module adder_tree_arbiter #(
  parameter int unsigned REQ_NUM         = 4,
  parameter int unsigned LAYER_NUM       = 4,
  parameter int unsigned MIN_ADDER_WIDTH = 8,
  parameter int unsigned TREE_LATENCY    = 4,
  localparam int unsigned DIN_W  = (2 ** (LAYER_NUM - 1)) * MIN_ADDER_WIDTH,
  localparam int unsigned DOUT_W = LAYER_NUM + MIN_ADDER_WIDTH,
  localparam int unsigned ID_W   = $clog2(REQ_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [REQ_NUM-1:0]         req_valid,
  output logic [REQ_NUM-1:0]         req_ready,
  input  logic [REQ_NUM*DIN_W-1:0]   req_data,
  output logic [DIN_W-1:0]           tree_din,
  input  logic [DOUT_W-1:0]          tree_dout,
  output logic [REQ_NUM-1:0]         rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DOUT_W-1:0]          rsp_data
`ifdef ADDER_TREE_ARB_ISSUE_CNT_EN
  ,
  output logic [31:0]                issue_cnt
`endif
);

  localparam int unsigned TAG_N = TREE_LATENCY + 1;
  localparam logic [REQ_NUM-1:0] ONE_HOT0 = REQ_NUM'(1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(REQ_NUM - 1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [DIN_W-1:0]   tree_din_q, tree_din_d;
  logic [TAG_N-1:0]   tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]    tag_id_q [TAG_N];
  logic [ID_W-1:0]    tag_id_d [TAG_N];
  logic [REQ_NUM-1:0] rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DOUT_W-1:0]  rsp_data_q, rsp_data_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic               issue;

  // Round-robin scan starting at the pointer, wrapping modulo REQ_NUM
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= REQ_NUM) begin
        idx = idx - REQ_NUM;
      end
      cand = ID_W'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign issue     = en && win_found && !rst;
  assign req_ready = issue ? (ONE_HOT0 << win_idx) : '0;

  // Issue path: pointer advance, operand register, tag insertion
  always_comb begin
    ptr_d      = ptr_q;
    tree_din_d = '0;
    if (issue) begin
      ptr_d = (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        if (ID_W'(i) == win_idx) begin
          tree_din_d = req_data[i*DIN_W +: DIN_W];
        end
      end
    end
  end

  // Tag pipeline tracks requester IDs alongside the tree, no stall
  always_comb begin
    tag_vld_d   = {tag_vld_q[TAG_N-2:0], issue};
    tag_id_d[0] = win_idx;
    for (int unsigned i = 1; i < TAG_N; i++) begin
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  // Response capture when the oldest tag lines up with tree_dout
  always_comb begin
    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[TAG_N-1]) begin
      rsp_valid_d = ONE_HOT0 << tag_id_q[TAG_N-1];
      rsp_id_d    = tag_id_q[TAG_N-1];
      rsp_data_d  = tree_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      tree_din_q  <= '0;
      tag_vld_q   <= '0;
      for (int unsigned i = 0; i < TAG_N; i++) begin
        tag_id_q[i] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tree_din_q  <= tree_din_d;
      tag_vld_q   <= tag_vld_d;
      for (int unsigned i = 0; i < TAG_N; i++) begin
        tag_id_q[i] <= tag_id_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign tree_din  = tree_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ADDER_TREE_ARB_ISSUE_CNT_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;

  // Saturating count of accepted issues
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (issue && (issue_cnt_q != '1)) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Scoreboard bench for adder_tree_arbiter with a behavioural adder-tree model.
module tb_adder_tree_arbiter;

  localparam int R      = 4;
  localparam int LN     = 4;
  localparam int MW     = 8;
  localparam int L      = 4;
  localparam int OPS    = 8;
  localparam int DIN_W  = OPS * MW;
  localparam int DOUT_W = LN + MW;
  localparam int ID_W   = 2;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [R-1:0]         req_valid;
  logic [R-1:0]         req_ready;
  logic [R*DIN_W-1:0]   req_data;
  logic [DIN_W-1:0]     tree_din;
  logic [DOUT_W-1:0]    tree_dout;
  logic [R-1:0]         rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [DOUT_W-1:0]    rsp_data;
`ifdef ADDER_TREE_ARB_ISSUE_CNT_EN
  logic [31:0]          issue_cnt;
`endif

  adder_tree_arbiter #(
    .REQ_NUM(R), .LAYER_NUM(LN), .MIN_ADDER_WIDTH(MW), .TREE_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .tree_din(tree_din), .tree_dout(tree_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ADDER_TREE_ARB_ISSUE_CNT_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ptr_m = 0;
  int   n_issue = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int sum_bytes(input logic [DIN_W-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < OPS; i++) s += int'(d[i*MW +: MW]);
    return s;
  endfunction

  // Adder tree stand-in: byte sum delayed by L clock edges
  logic [DOUT_W-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= DOUT_W'(sum_bytes(tree_din));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign tree_dout = pipe[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected result, on time
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.id);
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rsp_missing", 64'(rsp_valid), 64'(1) << e.id);
      end
    end
  end

  // Drive one cycle from a negedge; predict the grant from round-robin rules
  task automatic drive(input logic [R-1:0] v, input logic e);
    int win;
    logic [R-1:0] er;
    logic [DIN_W-1:0] ed;
    exp_t x;
    req_valid = v;
    en        = e;
    #1;
    win = -1;
    for (int i = 0; i < R; i++) begin
      int idx;
      idx = (ptr_m + i) % R;
      if (win < 0 && v[idx]) win = idx;
    end
    er = '0;
    ed = '0;
    if (e && win >= 0) begin
      er[win] = 1'b1;
      ed      = req_data[win*DIN_W +: DIN_W];
      x.id    = win;
      x.data  = sum_bytes(ed);
      x.due   = cyc + L + 2;
      q.push_back(x);
      ptr_m   = (win + 1) % R;
      n_issue++;
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    @(negedge clk);
    chk("tree_din", 64'(tree_din), 64'(ed));
  endtask

  task automatic set_pattern_data();
    for (int i = 0; i < R; i++) req_data[i*DIN_W +: DIN_W] = {OPS{8'(i + 1)}};
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) @(negedge clk);
    req_valid = '1;
    en = 1'b1;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_tree_din", 64'(tree_din), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    n_issue = 0;
    repeat (20) drive('0, 1'b1);

    // Single op from requester 1
    req_data[1*DIN_W +: DIN_W] = {OPS{8'h01}};
    drive(4'b0010, 1'b1);
    repeat (8) drive('0, 1'b1);

    // All requesters continuously valid
    set_pattern_data();
    repeat (12) drive('1, 1'b1);
    repeat (8) drive('0, 1'b1);

    // Maximum operand values
    req_data[3*DIN_W +: DIN_W] = '1;
    drive(4'b1000, 1'b1);
    repeat (8) drive('0, 1'b1);

    // Enable gating with in-flight drain
    set_pattern_data();
    repeat (2) drive('1, 1'b1);
    repeat (10) drive('1, 1'b0);
    repeat (3) drive('1, 1'b1);
    repeat (8) drive('0, 1'b1);

    // Reset while operations are in flight
    repeat (3) drive('1, 1'b1);
    repeat (2) drive('0, 1'b1);
    rst = 1'b1;
    q.delete();
    ptr_m = 0;
    n_issue = 0;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    drive('1, 1'b1);
    repeat (10) drive('0, 1'b1);

    // Random traffic
    repeat (300) begin
      for (int i = 0; i < R; i++) req_data[i*DIN_W +: DIN_W] = {$urandom, $urandom};
      drive(R'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (10) drive('0, 1'b1);

    chk("queue_drained", 64'(q.size()), 64'd0);
`ifdef ADDER_TREE_ARB_ISSUE_CNT_EN
    chk("issue_cnt", 64'(issue_cnt), 64'(n_issue));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_arbiter.md
Name: adder_tree_arbiter

Overview:
- Shares one pipelined adder tree between REQ_NUM requesters.
- Arbitrates round-robin, one issue per cycle, and drives the tree input.
- Tracks each issued operation's requester ID through a tag pipeline matched to the tree latency.
- Returns each sum to the requester that issued it. Sits between the compute clients and the adder tree instance.

Parameters:
- REQ_NUM, 4, number of requesters (2..16).
- LAYER_NUM, 4, tree layers; operands per issue = 2**(LAYER_NUM-1).
- MIN_ADDER_WIDTH, 8, operand width in bits.
- TREE_LATENCY, 4, clock edges from tree_din change to matching tree_dout (≥1).
- Derived: DIN_W = 2**(LAYER_NUM-1)*MIN_ADDER_WIDTH (default 64); DOUT_W = LAYER_NUM+MIN_ADDER_WIDTH (default 12); ID_W = clog2(REQ_NUM).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  issue enable; low blocks new grants, in-flight ops still drain.
- req_valid  in  REQ_NUM  per-requester operand vector valid.
- req_ready  out  REQ_NUM  per-requester accept, one-hot or zero.
- req_data  in  REQ_NUM*DIN_W  requester i at bits [i*DIN_W +: DIN_W].
- tree_din  out  DIN_W  registered operand vector to the adder tree.
- tree_dout  in  DOUT_W  sum from the adder tree.
- rsp_valid  out  REQ_NUM  one-hot result strobe, single cycle.
- rsp_id  out  ID_W  requester index of the current result.
- rsp_data  out  DOUT_W  result sum, unsigned.

Behaviour:
- Reset values (asynchronous, all outputs): tree_din=0, rsp_valid=0, rsp_id=0, rsp_data=0, RR pointer=0, all tag stages invalid. req_ready=0 while rst is high.
- Arbitration:
  - Combinational.
  - Winner = first i with req_valid[i]=1, scanning from pointer upward, wrapping modulo REQ_NUM.
  - req_ready[winner]=en; all other bits 0.
- Handshake: req_valid[i]&req_ready[i] at a rising edge = issue. Requesters must not depend on req_ready to raise req_valid. Data is sampled at that edge.
- Pointer update: on issue, pointer <= winner+1 (wraps to 0 after REQ_NUM-1). No issue -> pointer holds.
- tree_din: on issue, loads the winner's req_data; with no issue, loads 0.
- Tag pipeline:
  - TREE_LATENCY+1 stages of {valid, id}.
  - Stage 0 loads {1, winner} on issue, else {0, x}.
  - Shifts every cycle, with no stall.
- Response:
  - At the edge where the final tag stage is valid: rsp_valid <= onehot(id), rsp_id <= id, rsp_data <= tree_dout.
  - Otherwise rsp_valid <= 0, and rsp_id and rsp_data hold.
  - Latency: issue edge k -> rsp_valid high after edge k+TREE_LATENCY+1.
- Throughput: one issue per cycle sustained. Results return in issue order, no reordering. Responses cannot be backpressured; requesters must always accept.
- en low: no grants; pointer holds; pipeline keeps draining, so responses for earlier issues still appear.
- Single requester: granted every cycle while valid, pointer advances past it each time.
- Reset mid-operation: all in-flight tags are discarded. No response is produced for ops issued before reset. The first post-reset grant scans from index 0.
- Arithmetic: sum width DOUT_W holds 8 maximum operands with no overflow (max 8*255 = 2040). No truncation is performed by this block.

Optional Feature:
- Macro ADDER_TREE_ARB_ISSUE_CNT_EN.
- Defined:
  - Adds output issue_cnt, width 32.
  - Reset 0; increments by 1 per issue.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: rst pulse with all req_valid=0 -> all outputs 0, tree_din=0, no rsp_valid for 20 cycles.
- Single op:
  - Stimulus: req1 valid, data = eight bytes 0x01, en=1, defaults.
  - Grant: req_ready=4'b0010 for one cycle.
  - Result: 6 cycles after issue, rsp_valid=4'b0010, rsp_id=1, rsp_data=8.
- Round-robin fairness:
  - Stimulus: all four valid continuously, req i data = eight bytes of value i+1.
  - Grants: order 0,1,2,3,0,... one per cycle.
  - Results: rsp_data sequence 8,16,24,32 repeating, rsp_id matching, back-to-back.
- Max value: req3 data all 0xFF -> rsp_data=2040 (0x7F8), rsp_id=3.
- en gating: issue 2 ops, then en=0 with all valid for 10 cycles -> no req_ready. Both results still arrive 6 cycles after their issues. With en=1 again, grants resume from the saved pointer.
- Reset mid-flight: issue 3 back-to-back, assert rst 2 cycles after the last issue -> no rsp_valid for those ops. The first new issue after reset grants req0 when all are valid.
